// File: rtl/pipo_arb_pkg.sv
// Shared types and defaults for the round-robin PIPO arbiter and its picker.
package pipo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 4;

    // Increment an index modulo n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set req bit at or above ptr, wrapping modulo NREQ.
module rr_pick
    import pipo_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] winner,
    output logic            any_req
);

    int unsigned idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_req && req[idx[IDXW-1:0]]) begin
                winner  = idx[IDXW-1:0];
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipo_rr_arbiter.sv
// Round-robin sequencer sharing one PIPO register: arbitrate, load, read back and verify.
// Optional macro PIPO_RR_ARBITER_LOCK_EN adds a lock input that holds the pointer during LOAD.
module pipo_rr_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IDXW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef PIPO_RR_ARBITER_LOCK_EN
    input  logic                  lock,
`endif
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      pin,
    output logic                  pipo_en,
    input  logic [WIDTH-1:0]      pout,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  rerr,
    output logic [IDXW-1:0]       rid,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [IDXW-1:0]  widx_q, widx_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] pin_q, pin_d;
    logic             pipo_en_q, pipo_en_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             rerr_q, rerr_d;
    logic [IDXW-1:0]  rid_q, rid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] din_arr [NREQ];
    logic [IDXW-1:0]  winner;
    logic             any_req;
    logic             advance;

`ifdef PIPO_RR_ARBITER_LOCK_EN
    assign advance = ~lock;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            din_arr[i] = din[i*WIDTH +: WIDTH];
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // All visible outputs are computed one cycle ahead so they leave the block as flops.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        widx_d    = widx_q;
        gnt_d     = '0;
        pin_d     = pin_q;
        pipo_en_d = 1'b0;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        rerr_d    = rerr_q;
        rid_d     = rid_q;
        busy_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d       = LOAD;
                    wdata_d       = din_arr[winner];
                    widx_d        = winner;
                    gnt_d[winner] = 1'b1;
                    pin_d         = din_arr[winner];
                    pipo_en_d     = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            LOAD: begin
                state_d = CHECK;
                busy_d  = 1'b1;
                if (advance) begin
                    ptr_d = IDXW'(wrap_inc(32'(widx_q), NREQ));
                end
            end
            CHECK: begin
                state_d  = IDLE;
                rdata_d  = pout;
                rerr_d   = (pout != wdata_q);
                rid_d    = widx_q;
                rvalid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wdata_q   <= '0;
            widx_q    <= '0;
            gnt_q     <= '0;
            pin_q     <= '0;
            pipo_en_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
            rid_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            widx_q    <= widx_d;
            gnt_q     <= gnt_d;
            pin_q     <= pin_d;
            pipo_en_q <= pipo_en_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
            rid_q     <= rid_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign pin     = pin_q;
    assign pipo_en = pipo_en_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign rerr    = rerr_q;
    assign rid     = rid_q;
    assign busy    = busy_q;

endmodule
